// File: rtl/ghost_palette_sequencer_if.sv
// Ghost palette sequencer bus: game events in, per-ghost palette index and visibility out.
// master = game/event side, slave = sequencer.
interface ghost_palette_sequencer_if #(
    parameter int unsigned NUM_GHOSTS = 4
);
    logic                      frame_tick;
    logic                      power_pellet;
    logic [NUM_GHOSTS-1:0]     ghost_eaten;
    logic [NUM_GHOSTS-1:0]     ghost_home;
    logic [3*NUM_GHOSTS-1:0]   ghost_color_idx;
    logic [NUM_GHOSTS-1:0]     body_visible;
    logic                      fright_active;
    logic [1:0]                eat_combo;

    modport master (
        output frame_tick, power_pellet, ghost_eaten, ghost_home,
        input  ghost_color_idx, body_visible, fright_active, eat_combo
    );

    modport slave (
        input  frame_tick, power_pellet, ghost_eaten, ghost_home,
        output ghost_color_idx, body_visible, fright_active, eat_combo
    );
endinterface

// File: rtl/ghost_palette_sequencer.sv
// Per-ghost colour-mode controller for the 8-entry palette.
// Tracks NORMAL/FRIGHT/EATEN per ghost, runs the fright timer, and reports the eat combo.
// Define GHOST_FLASH_EN to build the blue/white flash at the end of fright; without it
// frightened ghosts stay blue until expiry.
module ghost_palette_sequencer #(
    parameter int unsigned NUM_GHOSTS    = 4,
    parameter int unsigned FRIGHT_FRAMES = 360,
    parameter int unsigned FLASH_FRAMES  = 120,
    parameter int unsigned FLASH_PERIOD  = 12
) (
    input  logic                        Clk,
    input  logic                        Reset,
    ghost_palette_sequencer_if.slave    seq_io
);

    localparam int unsigned CntW = $clog2(FRIGHT_FRAMES + 1);

    localparam logic [2:0] ColBlue  = 3'd4;
    localparam logic [2:0] ColWhite = 3'd5;

    // Elaboration-time parameter sanity.
    if (FLASH_FRAMES >= FRIGHT_FRAMES) begin : g_bad_flash_frames
        $error("FLASH_FRAMES must be less than FRIGHT_FRAMES");
    end
    if (FLASH_PERIOD < 1) begin : g_bad_flash_period
        $error("FLASH_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {
        StNormal,
        StFright,
        StEaten
    } ghost_state_e;

    ghost_state_e            state_q [NUM_GHOSTS];
    ghost_state_e            state_d [NUM_GHOSTS];
    logic [CntW-1:0]         fright_cnt_q, fright_cnt_d;
    logic [1:0]              combo_q, combo_d;
    logic                    expiry;
    logic                    flash_white;
    logic [NUM_GHOSTS-1:0]   eat_ok;
    logic [3*NUM_GHOSTS-1:0] color_idx;
    logic [NUM_GHOSTS-1:0]   visible;

    function automatic logic [2:0] base_color(input int unsigned g);
        case (g % 4)
            0:       return 3'd7;  // red
            1:       return 3'd1;  // pink
            2:       return 3'd2;  // cyan
            default: return 3'd3;  // orange
        endcase
    endfunction

    // Fright timer: pellet reloads, frame_tick counts down to zero without wrapping.
    always_comb begin
        fright_cnt_d = fright_cnt_q;
        if (seq_io.power_pellet) begin
            fright_cnt_d = CntW'(FRIGHT_FRAMES);
        end else if (seq_io.frame_tick && (fright_cnt_q != '0)) begin
            fright_cnt_d = fright_cnt_q - CntW'(1);
        end
        // A reload in the same cycle cancels expiry.
        expiry = seq_io.frame_tick && (fright_cnt_q == CntW'(1)) && !seq_io.power_pellet;
    end

`ifdef GHOST_FLASH_EN
    localparam int unsigned FlashW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

    logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
    logic              flash_phase_q, flash_phase_d;

    // Flash divider: counts frame_ticks and toggles the phase on each wrap.
    always_comb begin
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        if (seq_io.power_pellet) begin
            flash_cnt_d   = '0;
            flash_phase_d = 1'b0;
        end else if (seq_io.frame_tick) begin
            if (flash_cnt_q == FlashW'(FLASH_PERIOD - 1)) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FlashW'(1);
            end
        end
    end

    // Flash divider state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end

    assign flash_white = flash_phase_q && (fright_cnt_q != '0) &&
                         (fright_cnt_q <= CntW'(FLASH_FRAMES));
`else
    assign flash_white = 1'b0;
`endif

    // Per-ghost next state and eat combo.
    always_comb begin
        eat_ok  = '0;
        combo_d = combo_q;
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StNormal: begin
                    if (seq_io.power_pellet) state_d[i] = StFright;
                end
                StFright: begin
                    if (seq_io.ghost_eaten[i]) begin
                        eat_ok[i]  = 1'b1;
                        state_d[i] = StEaten;
                    end else if (expiry) begin
                        state_d[i] = StNormal;
                    end
                end
                StEaten: begin
                    // Pellet is ignored; home always returns to NORMAL.
                    if (seq_io.ghost_home[i]) state_d[i] = StNormal;
                end
                default: state_d[i] = StNormal;
            endcase
        end
        if (seq_io.power_pellet) begin
            // A new fright restarts the combo; an eat in the same cycle counts as the first.
            combo_d = (eat_ok != '0) ? 2'd1 : 2'd0;
        end else begin
            for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
                if (eat_ok[i] && (combo_d != 2'd3)) combo_d = combo_d + 2'd1;
            end
        end
    end

    // Ghost states, fright timer and combo.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_GHOSTS; i++) state_q[i] <= StNormal;
            fright_cnt_q <= '0;
            combo_q      <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_GHOSTS; i++) state_q[i] <= state_d[i];
            fright_cnt_q <= fright_cnt_d;
            combo_q      <= combo_d;
        end
    end

    // Colour and visibility decode from registered state.
    always_comb begin
        color_idx = '0;
        visible   = '0;
        for (int unsigned i = 0; i < NUM_GHOSTS; i++) begin
            color_idx[3*i +: 3] = base_color(i);
            visible[i]          = 1'b1;
            unique case (state_q[i])
                StFright: color_idx[3*i +: 3] = flash_white ? ColWhite : ColBlue;
                StEaten:  visible[i] = 1'b0;
                default:  ;
            endcase
        end
    end

    assign seq_io.ghost_color_idx = color_idx;
    assign seq_io.body_visible    = visible;
    assign seq_io.fright_active   = (fright_cnt_q != '0);
    assign seq_io.eat_combo       = combo_q;

endmodule

// File: tb/tb_ghost_palette_sequencer.sv
// Directed bench for ghost_palette_sequencer with FRIGHT_FRAMES=10, FLASH_FRAMES=4, FLASH_PERIOD=2.
// Expected flash colours depend on whether GHOST_FLASH_EN is defined for the build.
module tb_ghost_palette_sequencer;

`ifdef GHOST_FLASH_EN
    localparam bit FlashEn = 1'b1;
`else
    localparam bit FlashEn = 1'b0;
`endif

    localparam logic [11:0] IdxBase  = 12'h68F;  // {3,2,1,7}
    localparam logic [11:0] IdxBlue  = 12'h924;  // all 4
    localparam logic [11:0] IdxWhite = 12'hB6D;  // all 5

    logic Clk = 1'b0;
    logic Reset;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [11:0] flash_idx;

    ghost_palette_sequencer_if #(.NUM_GHOSTS(4)) gps_if ();

    ghost_palette_sequencer #(
        .NUM_GHOSTS   (4),
        .FRIGHT_FRAMES(10),
        .FLASH_FRAMES (4),
        .FLASH_PERIOD (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .seq_io(gps_if.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock with the given one-cycle pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic pp, input logic ft, input logic [3:0] eat,
                       input logic [3:0] home);
        gps_if.power_pellet = pp;
        gps_if.frame_tick   = ft;
        gps_if.ghost_eaten  = eat;
        gps_if.ghost_home   = home;
        @(posedge Clk);
        #1;
        gps_if.power_pellet = 1'b0;
        gps_if.frame_tick   = 1'b0;
        gps_if.ghost_eaten  = '0;
        gps_if.ghost_home   = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'h0, 4'h0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        flash_idx = FlashEn ? IdxWhite : IdxBlue;
        Reset = 1'b1;
        gps_if.power_pellet = 1'b0;
        gps_if.frame_tick   = 1'b0;
        gps_if.ghost_eaten  = '0;
        gps_if.ghost_home   = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        check("rst_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
        check("rst_vis", 16'(gps_if.body_visible), 16'h000F);
        check("rst_active", 16'(gps_if.fright_active), 16'h0000);
        check("rst_combo", 16'(gps_if.eat_combo), 16'h0000);

        // Pellet run: blue, flash on ticks 6..7 (state after), blue 8..9, base at 10
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        check("pp_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));
        check("pp_active", 16'(gps_if.fright_active), 16'h0001);
        for (int k = 1; k <= 10; k++) begin
            ticks(1);
            if (k == 10)
                check("run_idx_end", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
            else if (k == 6 || k == 7)
                check("run_idx_flash", 16'(gps_if.ghost_color_idx), 16'(flash_idx));
            else
                check("run_idx_blue", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));
            check("run_active", 16'(gps_if.fright_active), (k < 10) ? 16'h1 : 16'h0);
        end

        // Eat g0,g1 on tick 2, g0 home on tick 5
        do_reset();
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        ticks(1);
        cyc(1'b0, 1'b1, 4'b0011, 4'h0);
        check("eat2_combo", 16'(gps_if.eat_combo), 16'h0002);
        check("eat2_vis", 16'(gps_if.body_visible), 16'h000C);
        check("eat2_idx", 16'(gps_if.ghost_color_idx), 16'h090F);
        ticks(2);
        cyc(1'b0, 1'b1, 4'h0, 4'b0001);
        check("home_vis", 16'(gps_if.body_visible), 16'h000D);
        check("home_idx", 16'(gps_if.ghost_color_idx), 16'h090F);
        check("home_combo", 16'(gps_if.eat_combo), 16'h0002);
        check("home_active", 16'(gps_if.fright_active), 16'h0001);

        // Combo saturation, pellet clears it, home+pellet goes NORMAL
        do_reset();
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 4'b0001, 4'h0);
        check("combo1", 16'(gps_if.eat_combo), 16'h0001);
        cyc(1'b0, 1'b0, 4'b0010, 4'h0);
        check("combo2", 16'(gps_if.eat_combo), 16'h0002);
        cyc(1'b0, 1'b0, 4'b0100, 4'h0);
        check("combo3", 16'(gps_if.eat_combo), 16'h0003);
        cyc(1'b0, 1'b0, 4'b1000, 4'h0);
        check("combo_sat", 16'(gps_if.eat_combo), 16'h0003);
        check("all_eaten_vis", 16'(gps_if.body_visible), 16'h0000);
        check("all_eaten_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
        cyc(1'b1, 1'b0, 4'h0, 4'b0001);
        check("pp_combo_clr", 16'(gps_if.eat_combo), 16'h0000);
        check("pp_home_vis", 16'(gps_if.body_visible), 16'h0001);
        check("pp_home_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
        check("pp_reload", 16'(gps_if.fright_active), 16'h0001);
        cyc(1'b0, 1'b0, 4'h0, 4'b1110);
        check("home_all_vis", 16'(gps_if.body_visible), 16'h000F);
        // Leave flash phase at 1, then a pellet must reset it
        ticks(2);
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        check("pp2_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));
        ticks(6);
        check("phase_rst_t6", 16'(gps_if.ghost_color_idx), 16'(flash_idx));
        ticks(2);
        check("phase_rst_t8", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));

        // Pellet on the expiry tick reloads to 10
        do_reset();
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        ticks(9);
        cyc(1'b1, 1'b1, 4'h0, 4'h0);
        check("pp_exp_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));
        check("pp_exp_active", 16'(gps_if.fright_active), 16'h0001);
        ticks(9);
        check("pp_exp_t9_active", 16'(gps_if.fright_active), 16'h0001);
        check("pp_exp_t9_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBlue));
        ticks(1);
        check("pp_exp_t10_active", 16'(gps_if.fright_active), 16'h0000);
        check("pp_exp_t10_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));

        // Eat on the expiry tick wins
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        ticks(9);
        cyc(1'b0, 1'b1, 4'b0100, 4'h0);
        check("eat_exp_vis", 16'(gps_if.body_visible), 16'h000B);
        check("eat_exp_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
        check("eat_exp_combo", 16'(gps_if.eat_combo), 16'h0001);
        check("eat_exp_active", 16'(gps_if.fright_active), 16'h0000);
        cyc(1'b0, 1'b0, 4'h0, 4'b0100);

        // Pellet together with an eat gives combo 1
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 4'b0001, 4'h0);
        cyc(1'b0, 1'b0, 4'b0010, 4'h0);
        check("pe_combo2", 16'(gps_if.eat_combo), 16'h0002);
        cyc(1'b1, 1'b0, 4'b0100, 4'h0);
        check("pe_combo1", 16'(gps_if.eat_combo), 16'h0001);
        check("pe_vis", 16'(gps_if.body_visible), 16'h0008);
        check("pe_idx", 16'(gps_if.ghost_color_idx), 16'h088F);

        // Asynchronous reset mid-fright
        do_reset();
        cyc(1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 4'b0001, 4'h0);
        ticks(5);
        check("pre_rst_vis", 16'(gps_if.body_visible), 16'h000E);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));
        check("arst_vis", 16'(gps_if.body_visible), 16'h000F);
        check("arst_active", 16'(gps_if.fright_active), 16'h0000);
        check("arst_combo", 16'(gps_if.eat_combo), 16'h0000);
        #1;
        Reset = 1'b0;
        ticks(1);
        check("post_rst_active", 16'(gps_if.fright_active), 16'h0000);
        check("post_rst_idx", 16'(gps_if.ghost_color_idx), 16'(IdxBase));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
